// File: rtl/ddr4_pkg.sv
// Shared types and defaults for the DDR4 command scheduler front end.
package ddr4_pkg;

    localparam int BURST_LEN = 4;
    localparam int ROW_WIDTH = 16;
    localparam int COL_WIDTH = 10;
    localparam int WORD_SIZE = 8;

    localparam int T_RCD_DEF      = 2;
    localparam int T_RP_DEF       = 2;
    localparam int T_RFC_DEF      = 5;
    localparam int RD_LAT_DEF     = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam int TMR_W  = 8;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, XFER, REF, REF_WAIT
    } sched_state_t;

    typedef struct packed {
        logic                 we;
        logic                 burst;
        logic                 bg;
        logic [1:0]           ba;
        logic [ROW_WIDTH-1:0] row;
        logic [COL_WIDTH-1:0] col;
        logic [WORD_SIZE-1:0] data;
    } sched_req_t;

    // Wait counters load N-1 so the gap is exactly N cycles.
    function automatic logic [TMR_W-1:0] gap_load(input int n);
        return TMR_W'(n - 1);
    endfunction

endpackage

// File: rtl/ddr4_req_fifo.sv
// Request queue for the scheduler; pointers carry an extra MSB to tell full from empty.
module ddr4_req_fifo
    import ddr4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  sched_req_t push_data,
    input  logic       pop,
    output sched_req_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    sched_req_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ddr4_cmd_scheduler.sv
// Open-page DDR4 command scheduler with refresh gating and fixed-latency read return.
// Define CLOSED_PAGE_EN for auto-precharge on every transfer (closed-page policy).
module ddr4_cmd_scheduler
    import ddr4_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int T_RCD      = T_RCD_DEF,
    parameter int T_RP       = T_RP_DEF,
    parameter int T_RFC      = T_RFC_DEF,
    parameter int RD_LAT     = RD_LAT_DEF
) (
    input  logic                 clk_t,
    input  logic                 RESET,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic                 REQ_WE,
    input  logic                 REQ_BURST,
    input  logic                 REQ_BG,
    input  logic [1:0]           REQ_BA,
    input  logic [ROW_WIDTH-1:0] REQ_ROW,
    input  logic [COL_WIDTH-1:0] REQ_COL,
    input  logic [WORD_SIZE-1:0] REQ_DATA,
    input  logic                 REF_REQ,
    output logic                 REF_ACK,
    output logic                 BG,
    output logic [1:0]           BA,
    output logic                 ACT_n,
    output logic                 CS_n,
    output logic                 WE_n,
    output logic                 AP,
    output logic [ROW_WIDTH-1:0] ROW_ADDRESS,
    output logic [COL_WIDTH-1:0] COL_ADDRESS,
    output logic                 BURST_MODE,
    output logic [WORD_SIZE-1:0] DATAIN,
    input  logic [WORD_SIZE-1:0] DATAOUT,
    output logic                 RD_VALID,
    output logic [WORD_SIZE-1:0] RD_DATA
);

    sched_state_t         state;
    sched_state_t         state_nxt;
    sched_req_t           push_data;
    sched_req_t           head;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic [TMR_W-1:0]     tmr;
    logic [BEAT_W-1:0]    beat;
    logic                 open_valid;
    logic [2:0]           open_bank;
    logic [ROW_WIDTH-1:0] open_row;
    logic                 ref_pend;
    logic [RD_LAT-1:0]    rd_pipe;
    logic                 head_hit;
    logic                 last_beat;
    logic                 tmr_done;
    logic                 rd_beat;

    assign push_data = '{we: REQ_WE, burst: REQ_BURST, bg: REQ_BG, ba: REQ_BA,
                         row: REQ_ROW, col: REQ_COL, data: REQ_DATA};

    ddr4_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_t),
        .reset     (RESET),
        .push      (REQ_VALID),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign REQ_READY = !full && !RESET;
    assign head_hit  = open_valid && (open_bank == {head.bg, head.ba}) && (open_row == head.row);
    assign last_beat = !head.burst || (beat == BEAT_W'(BURST_LEN - 1));
    assign tmr_done  = (tmr == '0);
    assign pop       = (state == XFER) && last_beat;
    assign rd_beat   = (state == XFER) && !head.we;

    always_ff @(posedge clk_t) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (REF_REQ)          state_nxt = open_valid ? PRE : REF;
                else if (!empty) begin
                    if (head_hit)     state_nxt = XFER;
                    else if (open_valid) state_nxt = PRE;
                    else              state_nxt = ACT;
                end
            end
            PRE:      state_nxt = PRE_WAIT;
`ifdef CLOSED_PAGE_EN
            PRE_WAIT: if (tmr_done) state_nxt = IDLE;
`else
            PRE_WAIT: if (tmr_done) state_nxt = ref_pend ? REF : ACT;
`endif
            ACT:      state_nxt = ACT_WAIT;
            ACT_WAIT: if (tmr_done) state_nxt = XFER;
`ifdef CLOSED_PAGE_EN
            XFER:     if (last_beat) state_nxt = PRE_WAIT;
`else
            XFER:     if (last_beat) state_nxt = IDLE;
`endif
            REF:      state_nxt = REF_WAIT;
            REF_WAIT: if (tmr_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_t) begin
        if (RESET) begin
            tmr        <= '0;
            beat       <= '0;
            open_valid <= 1'b0;
            open_bank  <= '0;
            open_row   <= '0;
            ref_pend   <= 1'b0;
            rd_pipe    <= '0;
        end else begin
            case (state)
                PRE:      tmr <= gap_load(T_RP);
                ACT:      tmr <= gap_load(T_RCD);
                REF:      tmr <= gap_load(T_RFC);
`ifdef CLOSED_PAGE_EN
                XFER:     if (last_beat) tmr <= gap_load(T_RP);
`endif
                PRE_WAIT, ACT_WAIT, REF_WAIT: if (!tmr_done) tmr <= tmr - 1'b1;
                default:  ;
            endcase

            if (state == XFER) beat <= last_beat ? '0 : beat + 1'b1;
            else               beat <= '0;

            if (state == ACT) begin
                open_valid <= 1'b1;
                open_bank  <= {head.bg, head.ba};
                open_row   <= head.row;
            end else if (state == PRE) begin
                open_valid <= 1'b0;
            end
`ifdef CLOSED_PAGE_EN
            else if (state == XFER && last_beat) begin
                open_valid <= 1'b0;
            end
`endif

            // Refresh must survive the precharge detour even if REF_REQ drops.
            if (state == IDLE && REF_REQ && open_valid) ref_pend <= 1'b1;
            else if (state == REF)                      ref_pend <= 1'b0;

            for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
            rd_pipe[0] <= rd_beat;
        end
    end

    always_comb begin
        BG          = 1'b0;
        BA          = '0;
        ACT_n       = 1'b1;
        CS_n        = 1'b1;
        WE_n        = 1'b1;
        AP          = 1'b0;
        ROW_ADDRESS = '0;
        COL_ADDRESS = '0;
        BURST_MODE  = 1'b0;
        DATAIN      = '0;
        REF_ACK     = 1'b0;
        case (state)
            PRE: begin
                AP      = 1'b1;
                {BG, BA} = open_bank;
            end
            ACT: begin
                ACT_n       = 1'b0;
                BG          = head.bg;
                BA          = head.ba;
                ROW_ADDRESS = head.row;
            end
            XFER: begin
                // Column held constant; the controller advances it across the burst.
                ACT_n       = 1'b0;
                CS_n        = 1'b0;
                WE_n        = ~head.we;
                BG          = head.bg;
                BA          = head.ba;
                COL_ADDRESS = head.col;
                BURST_MODE  = head.burst;
                DATAIN      = head.data;
`ifdef CLOSED_PAGE_EN
                AP          = last_beat;
`endif
            end
            REF:     REF_ACK = 1'b1;
            default: ;
        endcase
    end

    assign RD_VALID = rd_pipe[RD_LAT-1];
    assign RD_DATA  = RD_VALID ? DATAOUT : '0;

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Directed bench for ddr4_cmd_scheduler: page hit/miss, bursts, queue full, refresh, reset.
module tb_ddr4_cmd_scheduler;
    import ddr4_pkg::*;

    logic                 clk_t = 1'b0;
    logic                 RESET = 1'b1;
    logic                 REQ_VALID = 1'b0;
    logic                 REQ_READY;
    logic                 REQ_WE = 1'b0;
    logic                 REQ_BURST = 1'b0;
    logic                 REQ_BG = 1'b0;
    logic [1:0]           REQ_BA = '0;
    logic [ROW_WIDTH-1:0] REQ_ROW = '0;
    logic [COL_WIDTH-1:0] REQ_COL = '0;
    logic [WORD_SIZE-1:0] REQ_DATA = '0;
    logic                 REF_REQ = 1'b0;
    logic                 REF_ACK;
    logic                 BG;
    logic [1:0]           BA;
    logic                 ACT_n, CS_n, WE_n, AP, BURST_MODE;
    logic [ROW_WIDTH-1:0] ROW_ADDRESS;
    logic [COL_WIDTH-1:0] COL_ADDRESS;
    logic [WORD_SIZE-1:0] DATAIN;
    logic [WORD_SIZE-1:0] DATAOUT = '0;
    logic                 RD_VALID;
    logic [WORD_SIZE-1:0] RD_DATA;

    int checks = 0;
    int errors = 0;

    always #5 clk_t = ~clk_t;

    ddr4_cmd_scheduler dut (
        .clk_t(clk_t), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_WE(REQ_WE), .REQ_BURST(REQ_BURST), .REQ_BG(REQ_BG), .REQ_BA(REQ_BA),
        .REQ_ROW(REQ_ROW), .REQ_COL(REQ_COL), .REQ_DATA(REQ_DATA),
        .REF_REQ(REF_REQ), .REF_ACK(REF_ACK), .BG(BG), .BA(BA), .ACT_n(ACT_n),
        .CS_n(CS_n), .WE_n(WE_n), .AP(AP), .ROW_ADDRESS(ROW_ADDRESS),
        .COL_ADDRESS(COL_ADDRESS), .BURST_MODE(BURST_MODE), .DATAIN(DATAIN),
        .DATAOUT(DATAOUT), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA)
    );

    task automatic tick;
        @(posedge clk_t);
        #1;
    endtask

    task automatic set_req(input logic we, input logic burst, input logic bg, input logic [1:0] ba,
                           input int row, input int col, input logic [7:0] data);
        REQ_WE = we; REQ_BURST = burst; REQ_BG = bg; REQ_BA = ba;
        REQ_ROW = ROW_WIDTH'(row); REQ_COL = COL_WIDTH'(col); REQ_DATA = WORD_SIZE'(data);
    endtask

    task automatic wait_act(output int n);
        n = 0;
        while (!(ACT_n === 1'b0 && CS_n === 1'b1) && n < 40) begin tick; n++; end
    endtask

    task automatic wait_xfer(output int n);
        n = 0;
        while (CS_n !== 1'b0 && n < 40) begin tick; n++; end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        tick; tick;
        checks++; if (ACT_n !== 1'b1 || CS_n !== 1'b1 || WE_n !== 1'b1) begin errors++; $display("FAIL rst_cmd_pins got act=%b cs=%b we=%b want 1 1 1", ACT_n, CS_n, WE_n); end
        checks++; if (AP !== 1'b0 || BURST_MODE !== 1'b0) begin errors++; $display("FAIL rst_ap_bm got ap=%b bm=%b want 0 0", AP, BURST_MODE); end
        checks++; if ({BG, BA, ROW_ADDRESS, COL_ADDRESS, DATAIN} !== '0) begin errors++; $display("FAIL rst_addr got %h want 0", {BG, BA, ROW_ADDRESS, COL_ADDRESS, DATAIN}); end
        checks++; if (REQ_READY !== 1'b0 || REF_ACK !== 1'b0 || RD_VALID !== 1'b0) begin errors++; $display("FAIL rst_hs got rdy=%b ack=%b rv=%b want 0 0 0", REQ_READY, REF_ACK, RD_VALID); end
        RESET = 1'b0;
        tick;
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", REQ_READY); end
    endtask

    task automatic test_write_act;
        int n;
        set_req(1'b1, 1'b0, 1'b0, 2'd1, 5, 3, 8'hA5);
        REQ_VALID = 1'b1;
        tick;
        REQ_VALID = 1'b0;
        wait_act(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL wr_act_lat got %0d want 1", n); end
        checks++; if (ROW_ADDRESS !== 16'd5 || BG !== 1'b0 || BA !== 2'd1) begin errors++; $display("FAIL wr_act_addr got row=%0d bg=%b ba=%0d want 5 0 1", ROW_ADDRESS, BG, BA); end
        wait_xfer(n);
        checks++; if (n !== 3) begin errors++; $display("FAIL wr_rcd_gap got %0d want 3", n); end
        checks++; if (WE_n !== 1'b0 || ACT_n !== 1'b0 || COL_ADDRESS !== 10'd3) begin errors++; $display("FAIL wr_xfer_pins got we=%b act=%b col=%0d want 0 0 3", WE_n, ACT_n, COL_ADDRESS); end
        checks++; if (DATAIN !== 8'hA5 || BURST_MODE !== 1'b0 || AP !== 1'b0) begin errors++; $display("FAIL wr_xfer_data got d=%h bm=%b ap=%b want a5 0 0", DATAIN, BURST_MODE, AP); end
        checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL wr_ready got %b want 1", REQ_READY); end
        tick;
        checks++; if (CS_n !== 1'b1) begin errors++; $display("FAIL wr_single_beat got cs=%b want 1", CS_n); end
    endtask

    task automatic test_page_hit;
        int  n;
        logic saw_act;
        DATAOUT = 8'hA5;
        set_req(1'b0, 1'b0, 1'b0, 2'd1, 5, 3, 8'h00);
        REQ_VALID = 1'b1;
        tick;
        REQ_VALID = 1'b0;
        n = 0; saw_act = 1'b0;
        while (CS_n !== 1'b0 && n < 40) begin
            tick; n++;
            if (ACT_n === 1'b0 && CS_n === 1'b1) saw_act = 1'b1;
        end
        checks++; if (n !== 1 || saw_act !== 1'b0) begin errors++; $display("FAIL hit_no_act got lat=%0d act=%b want 1 0", n, saw_act); end
        checks++; if (WE_n !== 1'b1) begin errors++; $display("FAIL hit_we_n got %b want 1", WE_n); end
        tick;
        checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL hit_rv_early got %b want 0", RD_VALID); end
        tick;
        checks++; if (RD_VALID !== 1'b1 || RD_DATA !== 8'hA5) begin errors++; $display("FAIL hit_rd got rv=%b d=%h want 1 a5", RD_VALID, RD_DATA); end
        tick;
        checks++; if (RD_VALID !== 1'b0) begin errors++; $display("FAIL hit_rv_late got %b want 0", RD_VALID); end
    endtask

    task automatic test_page_miss;
        int n;
        set_req(1'b1, 1'b0, 1'b0, 2'd1, 5, 4, 8'h3C);
        REQ_VALID = 1'b1;
        tick;
        set_req(1'b0, 1'b0, 1'b0, 2'd1, 9, 2, 8'h00);
        tick;
        REQ_VALID = 1'b0;
        wait_xfer(n);
        checks++; if (n !== 0 || WE_n !== 1'b0 || COL_ADDRESS !== 10'd4) begin errors++; $display("FAIL miss_wr got lat=%0d we=%b col=%0d want 0 0 4", n, WE_n, COL_ADDRESS); end
        n = 0;
        while (AP !== 1'b1 && n < 40) begin tick; n++; end
        checks++; if (n !== 2) begin errors++; $display("FAIL miss_pre_lat got %0d want 2", n); end
        checks++; if (CS_n !== 1'b1 || ACT_n !== 1'b1 || BG !== 1'b0 || BA !== 2'd1) begin errors++; $display("FAIL miss_pre_pins got cs=%b act=%b bg=%b ba=%0d want 1 1 0 1", CS_n, ACT_n, BG, BA); end
        wait_act(n);
        checks++; if (n !== 3 || ROW_ADDRESS !== 16'd9) begin errors++; $display("FAIL miss_act got gap=%0d row=%0d want 3 9", n, ROW_ADDRESS); end
        wait_xfer(n);
        checks++; if (n !== 3 || WE_n !== 1'b1 || COL_ADDRESS !== 10'd2) begin errors++; $display("FAIL miss_rd got gap=%0d we=%b col=%0d want 3 1 2", n, WE_n, COL_ADDRESS); end
        tick; tick; tick;
    endtask

    task automatic test_burst;
        int n;
        int bm_cnt;
        int rv_cnt;
        set_req(1'b0, 1'b1, 1'b0, 2'd1, 9, 0, 8'h00);
        REQ_VALID = 1'b1;
        tick;
        REQ_VALID = 1'b0;
        wait_xfer(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL burst_hit_lat got %0d want 1", n); end
        bm_cnt = 0; rv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            DATAOUT = 8'h30 + 8'(i);
            #1;
            if (BURST_MODE === 1'b1 && CS_n === 1'b0 && COL_ADDRESS === 10'd0) bm_cnt++;
            if (RD_VALID === 1'b1) begin
                checks++; if (i !== rv_cnt + 2 || RD_DATA !== 8'h30 + 8'(i)) begin errors++; $display("FAIL burst_beat got cyc=%0d d=%h want cyc=%0d d=%h", i, RD_DATA, rv_cnt + 2, 8'h32 + 8'(rv_cnt)); end
                rv_cnt++;
            end
            tick;
        end
        checks++; if (bm_cnt !== 4) begin errors++; $display("FAIL burst_mode_cycles got %0d want 4", bm_cnt); end
        checks++; if (rv_cnt !== 4) begin errors++; $display("FAIL burst_rd_count got %0d want 4", rv_cnt); end
        DATAOUT = '0;
    endtask

    task automatic test_fifo_full;
        int   acc;
        int   n;
        int   nx;
        logic prev_xfer;
        logic [COL_WIDTH-1:0] cols [5];
        REF_REQ = 1'b1;
        tick; tick;
        acc = 0; n = 0;
        set_req(1'b1, 1'b0, 1'b0, 2'd1, 9, 1, 8'h51);
        REQ_VALID = 1'b1;
        while (acc < 4 && n < 40) begin
            if (REQ_READY === 1'b1) acc++;
            tick; n++;
            set_req(1'b1, 1'b0, 1'b0, 2'd1, 9, acc + 1, 8'h50 + 8'(acc + 1));
        end
        checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", REQ_READY); end
        tick; tick; tick;
        checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL full_stalled got %b want 0", REQ_READY); end
        REF_REQ = 1'b0;
        n = 0; nx = 0; prev_xfer = 1'b0;
        while (REQ_READY !== 1'b1 && n < 60) begin
            prev_xfer = (CS_n === 1'b0);
            if (CS_n === 1'b0) begin cols[nx] = COL_ADDRESS; nx++; end
            tick; n++;
        end
        checks++; if (REQ_READY !== 1'b1 || prev_xfer !== 1'b1 || nx !== 1) begin errors++; $display("FAIL full_reopen got rdy=%b after_pop=%b pops=%0d want 1 1 1", REQ_READY, prev_xfer, nx); end
        tick;
        REQ_VALID = 1'b0;
        n = 0;
        while (nx < 5 && n < 200) begin
            if (CS_n === 1'b0) begin cols[nx] = COL_ADDRESS; nx++; end
            tick; n++;
        end
        checks++; if (nx !== 5) begin errors++; $display("FAIL full_drain got %0d want 5", nx); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (cols[k] !== COL_WIDTH'(k + 1)) begin errors++; $display("FAIL full_order[%0d] got %0d want %0d", k, cols[k], k + 1); end
        end
        tick; tick;
    endtask

    task automatic test_refresh;
        int n;
        set_req(1'b0, 1'b0, 1'b0, 2'd1, 9, 7, 8'h00);
        REQ_VALID = 1'b1;
        REF_REQ = 1'b1;
        tick;
        REQ_VALID = 1'b0;
        checks++; if (AP !== 1'b1 || CS_n !== 1'b1) begin errors++; $display("FAIL ref_pre got ap=%b cs=%b want 1 1", AP, CS_n); end
        n = 0;
        while (REF_ACK !== 1'b1 && n < 40) begin tick; n++; end
        checks++; if (n !== 3) begin errors++; $display("FAIL ref_ack_lat got %0d want 3", n); end
        REF_REQ = 1'b0;
        tick;
        checks++; if (REF_ACK !== 1'b0) begin errors++; $display("FAIL ref_ack_pulse got %b want 0", REF_ACK); end
        wait_act(n);
        checks++; if (n !== 6 || ROW_ADDRESS !== 16'd9) begin errors++; $display("FAIL ref_fresh_act got gap=%0d row=%0d want 6 9", n, ROW_ADDRESS); end
        wait_xfer(n);
        checks++; if (n !== 3 || COL_ADDRESS !== 10'd7 || WE_n !== 1'b1) begin errors++; $display("FAIL ref_serve got gap=%0d col=%0d we=%b want 3 7 1", n, COL_ADDRESS, WE_n); end
        tick; tick; tick; tick;
    endtask

    task automatic test_reset_mid_burst;
        int   n;
        logic busy;
        set_req(1'b0, 1'b1, 1'b0, 2'd1, 9, 0, 8'h00);
        REQ_VALID = 1'b1;
        tick;
        REQ_VALID = 1'b0;
        wait_xfer(n);
        tick;
        checks++; if (n !== 1 || CS_n !== 1'b0) begin errors++; $display("FAIL mid_burst_setup got lat=%0d cs=%b want 1 0", n, CS_n); end
        RESET = 1'b1;
        tick;
        checks++; if (ACT_n !== 1'b1 || CS_n !== 1'b1 || WE_n !== 1'b1 || AP !== 1'b0 || BURST_MODE !== 1'b0) begin errors++; $display("FAIL mid_rst_pins got act=%b cs=%b we=%b ap=%b bm=%b want 1 1 1 0 0", ACT_n, CS_n, WE_n, AP, BURST_MODE); end
        checks++; if ({BG, BA, ROW_ADDRESS, COL_ADDRESS, DATAIN} !== '0 || RD_VALID !== 1'b0 || REQ_READY !== 1'b0) begin errors++; $display("FAIL mid_rst_state got addr=%h rv=%b rdy=%b want 0 0 0", {BG, BA, ROW_ADDRESS, COL_ADDRESS, DATAIN}, RD_VALID, REQ_READY); end
        RESET = 1'b0;
        busy = 1'b0;
        repeat (8) begin
            tick;
            if (CS_n === 1'b0 || ACT_n === 1'b0 || RD_VALID === 1'b1) busy = 1'b1;
        end
        checks++; if (busy !== 1'b0 || REQ_READY !== 1'b1) begin errors++; $display("FAIL mid_rst_quiet got busy=%b rdy=%b want 0 1", busy, REQ_READY); end
    endtask

    initial begin
        test_reset;
        test_write_act;
        test_page_hit;
        test_page_miss;
        test_burst;
        test_fifo_full;
        test_refresh;
        test_reset_mid_burst;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule

// File: doc/ddr4_cmd_scheduler.md
Name: ddr4_cmd_scheduler

Overview:
- Front-end stage directly upstream of the DDR4 memory controller.
- Accepts host read/write requests through a valid/ready queue and tracks the single open bank/row (the controller has one sense amplifier).
- Converts each request into the controller's ACT/READ/WRITE/PRECHARGE pin sequence with programmable gaps, and returns read data at a fixed latency.
- Also gates periodic refresh.

Parameters:
- FIFO_DEPTH, 4, request queue entries (power of 2, ≥2)
- T_RCD, 2, cycles from ACT strobe to first RD/WR beat
- T_RP, 2, cycles from PRE strobe to next ACT
- T_RFC, 5, cycles refresh blocks new commands after REF_ACK
- RD_LAT, 2, cycles from a read beat to its DATAOUT sample

Ports:
- clk_t  in  1  controller clock (true phase)
- RESET  in  1  synchronous, active-high reset
- REQ_VALID  in  1  host request valid
- REQ_READY  out  1  queue can accept
- REQ_WE  in  1  1=write, 0=read
- REQ_BURST  in  1  1=BURST_LEN beats, 0=single beat
- REQ_BG  in  1  bank group
- REQ_BA  in  2  bank address
- REQ_ROW  in  ROW_WIDTH  row address
- REQ_COL  in  COL_WIDTH  column address
- REQ_DATA  in  WORD_SIZE  write data (held constant for the whole burst)
- REF_REQ  in  1  refresh request level
- REF_ACK  out  1  one-cycle refresh grant
- BG, BA, ACT_n, CS_n, WE_n, AP, ROW_ADDRESS, COL_ADDRESS, BURST_MODE, DATAIN  out  per controller  controller command pins
- DATAOUT  in  WORD_SIZE  controller read data
- RD_VALID  out  1  read beat valid
- RD_DATA  out  WORD_SIZE  read beat data

Behaviour:
- Reset values: ACT_n=1, CS_n=1, WE_n=1, AP=0, BURST_MODE=0; all address/data outputs 0; REQ_READY=0, REF_ACK=0, RD_VALID=0.
- Reset clears the queue, open-page state, timers and read pipe. Reset mid-operation aborts on that edge; no completion is owed.
- REQ_READY = !full, registered-free.
- A push happens when REQ_VALID && REQ_READY at posedge.
- When full, there is no push even if a pop occurs in the same cycle.
- Push and pop in the same non-full cycle are both honoured.
- Open page state: OPEN_VALID, OPEN_BANK={BG,BA}, OPEN_ROW.
- FSM states: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, XFER, REF, REF_WAIT.
- IDLE:
  - REF_REQ has priority. With OPEN_VALID it goes to PRE (then REF after the wait); without it, it goes to REF.
  - Otherwise, if the queue is non-empty, peek the head:
    - Hit (OPEN_VALID, bank and row match) → XFER.
    - Open page on a different bank or row → PRE.
    - No open page → ACT.
- PRE: one cycle, CS_n=1, AP=1, BG/BA=OPEN_BANK. Clears OPEN_VALID. Next state is PRE_WAIT.
- PRE_WAIT: counts T_RP cycles, then goes to ACT, or to REF if the refresh is pending.
- ACT: one cycle, ACT_n=0, CS_n=1, BG/BA/ROW_ADDRESS from head. Sets OPEN_*. Next state is ACT_WAIT for T_RCD cycles, then XFER.
- XFER: ACT_n=0, CS_n=0, WE_n=~REQ_WE, AP=0, COL_ADDRESS, BURST_MODE, DATAIN.
  - Duration is 1 cycle, or BURST_LEN cycles when burst; COL_ADDRESS stays constant because the controller increments it.
  - Pop on the last beat, then return to IDLE.
- REF: one cycle, REF_ACK=1. Then REF_WAIT for T_RFC cycles, then IDLE.
- Idle pins: ACT_n=1, CS_n=1, AP=0.
- Read return: each read beat pushes 1 into an RD_LAT-deep valid shift register.
  - When a 1 exits, RD_VALID=1 and RD_DATA=DATAOUT is sampled that cycle.
  - Beats are returned in order, with no backpressure.
- Column wrap: COL_ADDRESS+BURST_LEN overflow is not checked. The host must keep bursts within the row.
- Every wait counter loads N-1 so the gap is exactly N cycles. A value of 0 is illegal.

Optional Feature:
- Macro CLOSED_PAGE_EN.
- Defined:
  - Every XFER drives AP=1 on its last beat.
  - OPEN_VALID is cleared at the end of XFER, so every request takes the ACT path and PRE is never issued by the scheduler.
  - After XFER, T_RP cycles elapse before IDLE.
- Undefined: open-page policy as above.

Decomposition:
- ddr4_pkg additions:
  - sched_state_t enum
  - sched_req_t packed struct {we, burst, bg, ba, row, col, data}
  - T_* defaults
- BURST_LEN, ROW_WIDTH, COL_WIDTH and WORD_SIZE are reused from the package.
- One sub-module: ddr4_req_fifo (parameterised sched_req_t FIFO with full/empty, pointer wrap via extra MSB).

Test Plan:
- Reset then single write {BG0, BA1, row 5, col 3, 0xA5} → ACT_n=0 with ROW=5, then after T_RCD=2 one cycle CS_n=0, WE_n=0, COL=3, DATAIN=0xA5; REQ_READY=1 throughout.
- Page hit: read same bank/row col 3 → no ACT, XFER immediately; RD_VALID with RD_DATA=0xA5 RD_LAT=2 cycles after the beat.
- Page miss: write row 5 then read row 9 same bank → PRE (CS_n=1, AP=1), 2 idle cycles, ACT ROW=9, then read.
- Burst read BURST_LEN beats → BURST_MODE=1 for BURST_LEN cycles, BURST_LEN consecutive RD_VALID pulses in order.
- Push 5 requests with XFER stalled → REQ_READY drops after the 4th; the 5th is accepted only after the first pop.
- REF_REQ with an open page and a queued request → PRE, T_RP wait, REF_ACK pulse, T_RFC wait, then the request is served with a fresh ACT; RESET mid-burst → all pins at reset values on the next edge, RD_VALID=0.
